// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the single-ported main memory.
// Owns MAR/MBR_W/write, holds them for MEM_LAT cycles, then returns done plus read data.
module mem_arbiter #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req0,
  input  logic                 i_we0,
  input  logic [BITS_ADDR-1:0] i_addr0,
  input  logic [BITS_DATA-1:0] i_wdata0,
  output logic                 o_gnt0,
  output logic                 o_done0,
  input  logic                 i_req1,
  input  logic                 i_we1,
  input  logic [BITS_ADDR-1:0] i_addr1,
  input  logic [BITS_DATA-1:0] i_wdata1,
  output logic                 o_gnt1,
  output logic                 o_done1,
  output logic [BITS_DATA-1:0] o_rdata,
  output logic                 o_busy,
  output logic [BITS_ADDR-1:0] o_MAR,
  output logic [BITS_DATA-1:0] o_MBR_W,
  output logic                 o_write,
  input  logic [BITS_DATA-1:0] i_MBR_R
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t               r_state;
  logic                 r_last;
  logic [3:0]           r_cnt;
  logic                 r_weLat;

  logic                 w_anyReq;
  logic                 w_winner;
  logic                 w_weSel;
  logic [BITS_ADDR-1:0] w_addrSel;
  logic [BITS_DATA-1:0] w_wdataSel;

  // On a tie the requester that did not win last time goes next; r_last=1 after reset favours requester 0.
  always_comb begin
    w_anyReq = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      w_winner = ~r_last;
    end else begin
      w_winner = i_req1;
    end
    w_addrSel  = w_winner ? i_addr1  : i_addr0;
    w_wdataSel = w_winner ? i_wdata1 : i_wdata0;
    w_weSel    = w_winner ? i_we1    : i_we0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
      r_weLat <= 1'b0;
      o_gnt0  <= 1'b0;
      o_gnt1  <= 1'b0;
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      o_rdata <= '0;
      o_busy  <= 1'b0;
      o_MAR   <= '0;
      o_MBR_W <= '0;
      o_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done0 <= 1'b0;
          o_done1 <= 1'b0;
          if (w_anyReq) begin
            o_MAR   <= w_addrSel;
            o_MBR_W <= w_wdataSel;
            o_write <= w_weSel;
            r_weLat <= w_weSel;
            o_gnt0  <= ~w_winner;
            o_gnt1  <= w_winner;
            r_last  <= w_winner;
            r_cnt   <= CNT_INIT;
            o_busy  <= 1'b1;
            r_state <= BUSY;
          end else begin
            o_gnt0  <= 1'b0;
            o_gnt1  <= 1'b0;
            o_write <= 1'b0;
          end
        end
        BUSY: begin
          o_gnt0 <= 1'b0;
          o_gnt1 <= 1'b0;
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // r_last still names the owner of the access in flight.
            o_done0 <= ~r_last;
            o_done1 <= r_last;
            o_write <= 1'b0;
            o_busy  <= 1'b0;
            r_state <= IDLE;
            if (!r_weLat) begin
              o_rdata <= i_MBR_R;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a MEM_LAT=2 instance with a memory model for most checks,
// plus a MEM_LAT=1 instance for back-to-back throughput.
module tb_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        expWin;
    logic [31:0] expRdata;
  } vector_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        sReq0 = 0, sWe0 = 0, sReq1 = 0, sWe1 = 0;
  logic [15:0] sAddr0 = 0, sAddr1 = 0;
  logic [31:0] sWdata0 = 0, sWdata1 = 0;
  logic        sGnt0, sDone0, sGnt1, sDone1, sBusy, sWrite;
  logic [31:0] sRdata, sMbrW, sMbrR;
  logic [15:0] sMar;

  logic        fReq0 = 0;
  logic [15:0] fAddr0 = 0;
  logic        fGnt0, fDone0, fGnt1, fDone1, fBusy, fWrite;
  logic [31:0] fRdata, fMbrW, fMbrR;
  logic [15:0] fMar;

  int checks = 0;
  int failures = 0;

  bit [31:0] mem      [0:65535];
  bit        memValid [0:65535];

  always #5 clk = ~clk;

  // Unwritten locations read as {C0DE, address}, except 0x0010 which is preloaded with DEADBEEF.
  always @(posedge clk) begin
    if (sWrite) begin
      mem[sMar]      <= sMbrW;
      memValid[sMar] <= 1'b1;
    end
  end
  assign sMbrR = memValid[sMar] ? mem[sMar] :
                 (sMar == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, sMar};
  assign fMbrR = {16'h5A5A, fMar};

  mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req0(sReq0), .i_we0(sWe0), .i_addr0(sAddr0), .i_wdata0(sWdata0),
    .o_gnt0(sGnt0), .o_done0(sDone0),
    .i_req1(sReq1), .i_we1(sWe1), .i_addr1(sAddr1), .i_wdata1(sWdata1),
    .o_gnt1(sGnt1), .o_done1(sDone1),
    .o_rdata(sRdata), .o_busy(sBusy), .o_MAR(sMar), .o_MBR_W(sMbrW),
    .o_write(sWrite), .i_MBR_R(sMbrR)
  );

  mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(1)) dutFast (
    .clk(clk), .reset(reset),
    .i_req0(fReq0), .i_we0(1'b0), .i_addr0(fAddr0), .i_wdata0(32'h0),
    .o_gnt0(fGnt0), .o_done0(fDone0),
    .i_req1(1'b0), .i_we1(1'b0), .i_addr1(16'h0), .i_wdata1(32'h0),
    .o_gnt1(fGnt1), .o_done1(fDone1),
    .o_rdata(fRdata), .o_busy(fBusy), .o_MAR(fMar), .o_MBR_W(fMbrW),
    .o_write(fWrite), .i_MBR_R(fMbrR)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete access on the MEM_LAT=2 instance, from grant edge to done edge.
  task automatic applyStimulus(input vector_t v);
    logic [15:0] expAddr;
    logic        expWe;
    logic [31:0] expWdata;
    expAddr  = v.expWin ? v.addr1  : v.addr0;
    expWe    = v.expWin ? v.we1    : v.we0;
    expWdata = v.expWin ? v.wdata1 : v.wdata0;
    @(negedge clk);
    sReq0 = v.req0; sWe0 = v.we0; sAddr0 = v.addr0; sWdata0 = v.wdata0;
    sReq1 = v.req1; sWe1 = v.we1; sAddr1 = v.addr1; sWdata1 = v.wdata1;
    @(posedge clk); #1;
    checkOutput("gnt0", 32'(sGnt0), 32'(!v.expWin));
    checkOutput("gnt1", 32'(sGnt1), 32'(v.expWin));
    checkOutput("doneAtGnt", 32'({sDone0, sDone1}), 32'h0);
    checkOutput("busyAtGnt", 32'(sBusy), 32'h1);
    checkOutput("marAtGnt", 32'(sMar), 32'(expAddr));
    checkOutput("writeAtGnt", 32'(sWrite), 32'(expWe));
    if (expWe) checkOutput("mbrwAtGnt", sMbrW, expWdata);
    sReq0 = 0; sReq1 = 0;
    sAddr0 = 16'hFFFF; sAddr1 = 16'hFFFF; sWe0 = ~expWe; sWe1 = ~expWe;
    sWdata0 = 32'h0; sWdata1 = 32'h0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
      checkOutput("gntHeld", 32'({sGnt0, sGnt1}), 32'h0);
      checkOutput("doneEarly", 32'({sDone0, sDone1}), 32'h0);
      checkOutput("marHeld", 32'(sMar), 32'(expAddr));
      checkOutput("writeHeld", 32'(sWrite), 32'(expWe));
    end
    @(posedge clk); #1;
    checkOutput("done0", 32'(sDone0), 32'(!v.expWin));
    checkOutput("done1", 32'(sDone1), 32'(v.expWin));
    checkOutput("writeAtDone", 32'(sWrite), 32'h0);
    checkOutput("busyAtDone", 32'(sBusy), 32'h0);
    checkOutput("rdata", sRdata, v.expRdata);
  endtask

  vector_t table_v [8];
  int grantWho [8];
  int grantCyc [8];
  int nGrants;
  int nDones;
  vector_t v5;

  initial begin
    table_v[0] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 32'h0, 32'h0, 0, 32'hDEADBEEF};
    table_v[1] = '{0, 1, 0, 1, 16'h0000, 16'h0100, 32'h0, 32'h12345678, 1, 32'hDEADBEEF};
    table_v[2] = '{1, 0, 0, 0, 16'h0100, 16'h0000, 32'h0, 32'h0, 0, 32'h12345678};
    table_v[3] = '{1, 1, 0, 0, 16'h0020, 16'h0030, 32'h0, 32'h0, 1, 32'hC0DE0030};
    table_v[4] = '{1, 1, 0, 0, 16'h0020, 16'h0030, 32'h0, 32'h0, 0, 32'hC0DE0020};
    table_v[5] = '{0, 1, 0, 0, 16'h0000, 16'h0100, 32'h0, 32'h0, 1, 32'h12345678};
    table_v[6] = '{1, 0, 1, 0, 16'h0040, 16'h0000, 32'hAAAA5555, 32'h0, 0, 32'h12345678};
    table_v[7] = '{0, 1, 0, 0, 16'h0000, 16'h0040, 32'h0, 32'h0, 1, 32'hAAAA5555};

    // Reset held for two cycles; everything must come up zero.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstGnt", 32'({sGnt0, sGnt1, sDone0, sDone1}), 32'h0);
    checkOutput("rstBusy", 32'(sBusy), 32'h0);
    checkOutput("rstMar", 32'(sMar), 32'h0);
    checkOutput("rstWrite", 32'(sWrite), 32'h0);
    checkOutput("rstRdata", sRdata, 32'h0);
    checkOutput("rstMbrW", sMbrW, 32'h0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 8; i++) applyStimulus(table_v[i]);

    // Both requesters held high straight out of reset: strict 0,1,0,1 alternation every LAT+1 cycles.
    @(negedge clk);
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    sReq0 = 1; sWe0 = 0; sAddr0 = 16'h0010;
    sReq1 = 1; sWe1 = 0; sAddr1 = 16'h0020;
    nGrants = 0;
    nDones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checkOutput("noDoubleGrant", 32'(sGnt0 & sGnt1), 32'h0);
      if ((sGnt0 || sGnt1) && nGrants < 8) begin
        grantWho[nGrants] = sGnt1 ? 1 : 0;
        grantCyc[nGrants] = c;
        nGrants++;
      end
      if (sDone0 || sDone1) nDones++;
    end
    @(negedge clk);
    sReq0 = 0; sReq1 = 0;
    checkOutput("rrGrantCount", 32'(nGrants), 32'd4);
    checkOutput("rrDoneCount", 32'(nDones), 32'd4);
    for (int g = 0; g < 4 && g < nGrants; g++) begin
      checkOutput("rrOrder", 32'(grantWho[g]), 32'(g % 2));
      checkOutput("rrSpacing", 32'(grantCyc[g]), 32'(g * (LAT + 1)));
    end

    // Reset lands while a write is in flight; the access must vanish without a done pulse.
    @(posedge clk);
    @(negedge clk);
    sReq1 = 1; sWe1 = 1; sAddr1 = 16'h0050; sWdata1 = 32'h0BADF00D;
    @(posedge clk); #1;
    checkOutput("abortGnt1", 32'(sGnt1), 32'h1);
    checkOutput("abortWriteOn", 32'(sWrite), 32'h1);
    sReq1 = 0;
    reset = 1;
    @(posedge clk); #1;
    checkOutput("abortWrite", 32'(sWrite), 32'h0);
    checkOutput("abortBusy", 32'(sBusy), 32'h0);
    checkOutput("abortDone", 32'({sDone0, sDone1}), 32'h0);
    checkOutput("abortMar", 32'(sMar), 32'h0);
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("abortNoDone", 32'({sDone0, sDone1}), 32'h0);
    end
    v5 = '{1, 0, 0, 0, 16'h0010, 16'h0000, 32'h0, 32'h0, 0, 32'hDEADBEEF};
    applyStimulus(v5);

    // MEM_LAT=1 with requester 0 held: grant and done alternate every cycle.
    @(negedge clk);
    fReq0 = 1; fAddr0 = 16'h0070;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checkOutput("fastGnt0", 32'(fGnt0), 32'(c % 2 == 0));
      checkOutput("fastDone0", 32'(fDone0), 32'(c % 2 == 1));
      if (c % 2 == 1) checkOutput("fastRdata", fRdata, 32'h5A5A0070);
    end
    @(negedge clk);
    fReq0 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
